// File: rtl/logic_gate_array.sv
// logic_gate_array
//   Two-stage valid/ready pipeline that reduces NUM_IN operands of WIDTH bits
//   with a selectable bitwise operation and counts completed handoffs.
//
//   Op[1:0] : 00 AND, 01 OR, 10 XOR (per-bit parity), 11 PASS operand 0
//   Op[2]   : invert result, only when LOGIC_GATE_ARRAY_INVERT_EN is defined;
//             otherwise ignored and not stored.
//
// Ports
//   Clk       in   clock, all state on rising edge
//   Rst_n     in   asynchronous active-low reset
//   In        in   packed operands, operand k = In[k*WIDTH +: WIDTH]
//   Op        in   operation select, sampled with In
//   InValid   in   upstream offers In/Op
//   InReady   out  block accepts In/Op this cycle
//   F         out  registered result
//   OutValid  out  F holds a valid result
//   OutReady  in   downstream accepts F this cycle
//   Count     out  number of results handed off, wraps
//
// Configuration macro: LOGIC_GATE_ARRAY_INVERT_EN

module logic_gate_array #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic [2:0]              Op,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [WIDTH-1:0]        F,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [CNT_W-1:0]        Count
);

`ifdef LOGIC_GATE_ARRAY_INVERT_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
  // Op[2] has no function in this build.
  logic op2_unused;
  assign op2_unused = Op[2];
`endif

  logic [NUM_IN*WIDTH-1:0] s1_in;
  logic [OP_W-1:0]         s1_op;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s2_load;
  logic                    accept;
  logic                    handoff;
  logic [WIDTH-1:0]        result;

  // S2 can take a new result when empty or when its current one leaves now.
  assign s2_load  = s1_valid && (!s2_valid || OutReady);
  // Ready looks through to OutReady so a full pipeline still streams.
  assign InReady  = !s1_valid || s2_load;
  assign accept   = InValid && InReady;
  assign handoff  = s2_valid && OutReady;
  assign OutValid = s2_valid;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_in    <= '0;
      s1_op    <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_in <= In;
        s1_op <= Op[OP_W-1:0];
      end
      if (accept)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_xor;
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    result  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_and = red_and & s1_in[k*WIDTH +: WIDTH];
      red_or  = red_or  | s1_in[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ s1_in[k*WIDTH +: WIDTH];
    end
    case (s1_op[1:0])
      2'b00:   result = red_and;
      2'b01:   result = red_or;
      2'b10:   result = red_xor;
      default: result = s1_in[WIDTH-1:0];
    endcase
`ifdef LOGIC_GATE_ARRAY_INVERT_EN
    if (s1_op[2])
      result = ~result;
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      F        <= '0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_load)
        F <= result;
      if (s2_load)
        s2_valid <= 1'b1;
      else if (handoff)
        s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      Count <= '0;
    else if (handoff)
      Count <= Count + 1'b1;
  end

endmodule
